// File: rtl/cond_pkg.sv
// -----------------------------------------------------------------------------
// cond_pkg
// Shared definitions for the multi-cycle condition unit: ARM condition codes,
// NZCV bit positions, FlagW group masks, the control FSM state type and a
// helper that merges a new NZCV value into the architectural one under FlagW.
// -----------------------------------------------------------------------------
package cond_pkg;

   // ARM condition field encodings
   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   // NZCV bit indices
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Flag bits covered by each FlagW enable: FlagW[1] -> N,Z ; FlagW[0] -> C,V
   localparam logic [3:0] FLAGW_NZ_MASK = 4'b1100;
   localparam logic [3:0] FLAGW_CV_MASK = 4'b0011;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_e;

   // Replace only the FlagW-selected groups of old_flags with new_flags.
   function automatic logic [3:0] flag_merge(input logic [3:0] old_flags,
                                             input logic [3:0] new_flags,
                                             input logic [1:0] flagw);
      logic [3:0] mask;
      mask = ({4{flagw[1]}} & FLAGW_NZ_MASK) | ({4{flagw[0]}} & FLAGW_CV_MASK);
      return (old_flags & ~mask) | (new_flags & mask);
   endfunction

endpackage

// File: rtl/cond_unit_mc_if.sv
// -----------------------------------------------------------------------------
// cond_unit_mc_if
// Bundle of Decode-stage controls, multi-cycle unit handshake and gated
// write enables seen by the condition unit.
//   slave  : the condition unit (consumes controls/handshake, drives enables)
//   master : the pipeline/environment driving it
// -----------------------------------------------------------------------------
interface cond_unit_mc_if;
   // Pipeline control and instruction fields
   logic       Valid;
   logic       Stall;
   logic       Flush;
   logic [3:0] Cond;
   logic [1:0] FlagW;
   logic       PCS;
   logic       RegW;
   logic       MemW;
   logic       NoWrite;
   logic       MS;
   logic [3:0] ALUFlags;
   // Multi-cycle unit response
   logic       MDone;
   logic [3:0] MFlags;
   // Gated enables and status
   logic       PCSrc;
   logic       RegWrite;
   logic       MemWrite;
   logic       MStart;
   logic       MRegWrite;
   logic       MBusy;
   logic       MErr;
   logic       CondEx;
   logic [3:0] Flags;
   logic       Carry;

   modport slave (
      input  Valid, Stall, Flush, Cond, FlagW, PCS, RegW, MemW, NoWrite, MS,
             ALUFlags, MDone, MFlags,
      output PCSrc, RegWrite, MemWrite, MStart, MRegWrite, MBusy, MErr,
             CondEx, Flags, Carry
   );

   modport master (
      output Valid, Stall, Flush, Cond, FlagW, PCS, RegW, MemW, NoWrite, MS,
             ALUFlags, MDone, MFlags,
      input  PCSrc, RegWrite, MemWrite, MStart, MRegWrite, MBusy, MErr,
             CondEx, Flags, Carry
   );
endinterface

// File: rtl/cond_eval.sv
// -----------------------------------------------------------------------------
// cond_eval
// Purely combinational ARM condition evaluation.
//   cond    : 4-bit condition field
//   flags   : architectural NZCV
//   cond_ex : 1 when the instruction is to execute
// -----------------------------------------------------------------------------
module cond_eval
   import cond_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       cond_ex
);

   logic n, z, c, v;

   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign c = flags[FLAG_C];
   assign v = flags[FLAG_V];

   always_comb begin
      case (cond)
         COND_EQ: cond_ex = z;
         COND_NE: cond_ex = ~z;
         COND_CS: cond_ex = c;
         COND_CC: cond_ex = ~c;
         COND_MI: cond_ex = n;
         COND_PL: cond_ex = ~n;
         COND_VS: cond_ex = v;
         COND_VC: cond_ex = ~v;
         COND_HI: cond_ex = c & ~z;
         COND_LS: cond_ex = ~c | z;
         COND_GE: cond_ex = (n == v);
         COND_LT: cond_ex = (n != v);
         COND_GT: cond_ex = ~z & (n == v);
         COND_LE: cond_ex = z | (n != v);
         COND_AL: cond_ex = 1'b1;
         default: cond_ex = 1'b0;   // COND_NV never executes
      endcase
   end

endmodule

// File: rtl/cond_unit_mc.sv
// -----------------------------------------------------------------------------
// cond_unit_mc
// Execute-stage condition unit with pipeline control and a multi-cycle
// operation handshake. Single-cycle instructions gate PC/register/memory
// writes and update NZCV one edge later. A multi-cycle instruction pulses
// MStart, holds MBusy (hazard-unit stall) while waiting, and on MDone commits
// the FlagW groups latched at issue from MFlags plus a one-cycle MRegWrite.
// Flush aborts an in-flight operation; running out of TIMEOUT_CYC wait
// cycles abandons it and sets the sticky MErr.
//   CLK    : rising-edge clock
//   ResetN : asynchronous active-low reset
//   bus    : controls, handshake and gated enables (slave modport)
// -----------------------------------------------------------------------------
module cond_unit_mc
   import cond_pkg::*;
#(
   parameter int         TIMEOUT_CYC = 64,
   parameter int         CNT_W       = $clog2(TIMEOUT_CYC + 1),
   parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
   input  logic           CLK,
   input  logic           ResetN,
   cond_unit_mc_if.slave  bus
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       flags_q, flags_d;
   logic [1:0]       flagw_q, flagw_d;    // FlagW captured at multi-cycle issue
   logic             mregw_q, mregw_d;    // RegW & ~NoWrite captured at issue
   logic             merr_q, merr_d;

   logic cond_ex;
   logic go;
   logic timeout;
   logic m_commit;

   cond_eval u_cond_eval (
      .cond    (bus.Cond),
      .flags   (flags_q),
      .cond_ex (cond_ex)
   );

   // Only an IDLE unit accepts instructions; in WAIT, go is forced low so
   // every write enable and MStart stay quiet whatever the inputs do.
   assign go       = bus.Valid & cond_ex & ~bus.Stall & ~bus.Flush & (state_q == IDLE);
   assign timeout  = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
   // Flush outranks MDone in the same cycle
   assign m_commit = (state_q == WAIT) & ~bus.Flush & bus.MDone;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
   // so the order of these statements cannot change behaviour.
   always_ff @(posedge CLK or negedge ResetN) begin
      if (!ResetN) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         flags_q <= RESET_FLAGS;
         flagw_q <= '0;
         mregw_q <= 1'b0;
         merr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         flags_q <= flags_d;
         flagw_q <= flagw_d;
         mregw_q <= mregw_d;
         merr_q  <= merr_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   // NOTE: every variable is given a default at the top of the block so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (go && bus.MS) state_d = WAIT;
         WAIT:    if (bus.Flush || bus.MDone || timeout) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values: counter, flags, issue-time latches, error flag
   always_comb begin
      cnt_d   = cnt_q;
      flags_d = flags_q;
      flagw_d = flagw_q;
      mregw_d = mregw_q;
      merr_d  = merr_q;
      if (state_q == IDLE) begin
         if (go && !bus.MS) begin
            flags_d = flag_merge(flags_q, bus.ALUFlags, bus.FlagW);
         end
         if (go && bus.MS) begin
            flagw_d = bus.FlagW;
            mregw_d = bus.RegW & ~bus.NoWrite;
            cnt_d   = '0;
         end
      end else begin
         // Leaves WAIT no later than cnt_q == TIMEOUT_CYC-1, so it never wraps
         cnt_d = cnt_q + CNT_W'(1);
         if (m_commit) begin
            flags_d = flag_merge(flags_q, bus.MFlags, flagw_q);
         end else if (!bus.Flush && timeout) begin
            merr_d = 1'b1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Output logic
   // -------------------------------------------------------------------------
   always_comb begin
      bus.PCSrc     = bus.PCS & go;
      bus.RegWrite  = bus.RegW & go & ~bus.NoWrite & ~bus.MS;
      bus.MemWrite  = bus.MemW & go & ~bus.MS;
      bus.MStart    = go & bus.MS;
      bus.MRegWrite = m_commit & mregw_q;
      bus.MBusy     = (state_q == WAIT);
      bus.MErr      = merr_q;
      bus.CondEx    = cond_ex;
      bus.Flags     = flags_q;
      bus.Carry     = flags_q[FLAG_C];
   end

endmodule
